// File: rtl/des_key_sched.sv
// DES key-schedule generator: loads C||D once, then streams K1..K16 (or K16..K1) over valid/ready.
// Define DES_KS_PC1_EN to accept the raw 64-bit key and apply PC-1 at load.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
`ifdef DES_KS_PC1_EN
  input  logic [63:0] key_in,
`else
  input  logic [55:0] key_in,
`endif
  output logic        busy,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] key_out,
  output logic [3:0]  key_round,
  output logic        key_last
);

  typedef enum logic {IDLE, RUN} state_t;

  // Tables use DES 1-based bit numbers; vector index = DES bit - 1.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic [55:0] cd;
  logic [3:0]  j;
  logic        dir;
  logic [55:0] load_cd;
  logic [55:0] step_cd;
  logic [4:0]  n_enc;
  logic [4:0]  n_dec;

  // A DES left rotation moves bit i+1 into bit i, i.e. toward index 0.
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // Shift amount s(n) is 1 for rounds 1, 2, 9, 16 and 2 otherwise.
  function automatic logic is_two(input logic [4:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

`ifdef DES_KS_PC1_EN
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  always_comb begin
    load_cd = '0;
    for (int k = 0; k < 56; k++) load_cd[k] = key_in[PC1[k] - 1];
  end
`else
  assign load_cd = key_in;
`endif

  assign n_enc = {1'b0, j} + 5'd2;
  assign n_dec = 5'd16 - {1'b0, j};

  always_comb begin
    if (dir)
      step_cd = {rotr(cd[55:28], is_two(n_dec)), rotr(cd[27:0], is_two(n_dec))};
    else
      step_cd = {rotl(cd[55:28], is_two(n_enc)), rotl(cd[27:0], is_two(n_enc))};
  end

  // Encrypt applies s1 while loading so K1 is presented on the first valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cd        <= '0;
      j         <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cd        <= decrypt ? load_cd
                                 : {rotl(load_cd[55:28], 1'b0), rotl(load_cd[27:0], 1'b0)};
            dir       <= decrypt;
            j         <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            key_valid <= 1'b1;
          end
        end
        RUN: begin
          if (key_valid && key_ready) begin
            if (j == 4'd15) begin
              state     <= IDLE;
              busy      <= 1'b0;
              key_valid <= 1'b0;
              j         <= '0;
            end else begin
              cd <= step_cd;
              j  <= j + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    key_out = '0;
    for (int k = 0; k < 48; k++) key_out[k] = cd[PC2[k] - 1];
  end

  assign key_round = key_valid ? (dir ? 4'd15 - j : j) : 4'd0;
  assign key_last  = key_valid && (j == 4'd15);

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key-schedule generator. It accepts one 56-bit post-PC-1 key (C||D), then streams the 16 48-bit round subkeys over a valid/ready handshake. Encrypt order is K1..K16, produced by left rotations. Decrypt order is K16..K1, produced by right rotations. It sits between key load and the round datapath; PC-2 is applied internally as pure wiring on the C/D register.

## Interface
Bit-order rule for all key vectors: index 0 = DES bit 1 (FIPS 46-3 numbering), index n-1 = DES bit n. C = key bits [27:0], D = key bits [55:28].

Parameters:
- none; widths are fixed by DES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  load request, sampled only in IDLE.
- decrypt  in  1  order select, sampled with start: 0 = K1..K16, 1 = K16..K1.
- key_in  in  56 (64 with DES_KS_PC1_EN)  key; post-PC-1 C||D, or the raw key with parity bits.
- busy  out  1  high from the cycle after start acceptance until the last transfer completes.
- key_valid  out  1  a subkey is presented.
- key_ready  in  1  consumer accepts; a transfer occurs when key_valid && key_ready.
- key_out  out  48  subkey = PC-2(current C||D).
- key_round  out  4  DES round index minus 1 (0..15) of the presented subkey.
- key_last  out  1  high with the 16th subkey of the sequence.

## Operation
- States: IDLE and RUN. A 4-bit step counter j counts 0..15 and a dir register holds the sampled decrypt value.
- Start acceptance: in IDLE, start=1 loads CD ← key_in, dir ← decrypt, j ← 0, and moves to RUN. start is ignored in RUN.
- Shift schedule, step s1..s16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt: CD is loaded as CD0. At j=0, CD is first rotated by s1, so the first key presented is K1. On each transfer at step j<15, C and D are each rotated left (in DES terms) by s(j+2).
- Decrypt: the first key presented is PC-2(CD0) = K16, because the total rotation is 28. On each transfer at step j<15, C and D are each rotated right by s(16-j): 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotation definition: a DES left rotation by 1 of C gives new C[i] = old C[i+1] and new C[27] = old C[0]. D is rotated the same way within [55:28].
- key_round: j in encrypt mode, 15-j in decrypt mode. key_last = (j==15).
- Transfer at j=15 returns the block to IDLE. busy and key_valid go low the next cycle.
- Outputs are stable while key_valid=1 and key_ready=0. CD is not modified without a transfer.
- rst in any state forces IDLE and clears all outputs, dropping any partial sequence. rst wins over a simultaneous start.

## Timing
- Reset values: busy=0, key_valid=0, key_out=0, key_round=0, key_last=0. The CD register is cleared.
- Latency: start accepted at edge N gives key_valid=1 from edge N+1.
- Throughput: 1 subkey/cycle with key_ready held high. 16 transfers take 16 cycles, so a sequence is 17 cycles from start to IDLE.
- A start held high through the last transfer is accepted in the first IDLE cycle. That is at least one idle cycle between sequences, with no back-to-back overlap.
- key_out is combinational from the CD register only. No path from key_ready to key_out.

## Configuration
- DES_KS_PC1_EN defined:
  - key_in is 64 bits: the raw key with parity bits 8,16,..,64.
  - PC-1 is applied at load; the parity bits are ignored.
- DES_KS_PC1_EN undefined:
  - key_in is 56 bits, already PC-1 permuted, and is loaded directly.
  - No other behaviour differs.

## Test plan
Vectors below are written MSB-first in DES bit order, so the leftmost hex digit holds DES bits 1-4, i.e. vector indices [0..3].
- Reset: rst for 2 cycles mid-RUN → next cycle busy=0, key_valid=0, key_out=0; a following start begins a fresh sequence.
- Encrypt, key_ready=1, CD0=F0CCAAF556678F:
  - first key is key_round=0, key_out=1B02EFFC7072.
  - 16th key is key_round=15, key_out=CB3D8B0E17F5, key_last=1.
  - busy drops 17 cycles after start.
- Decrypt, same CD0: first key_out=CB3D8B0E17F5 with key_round=15; last key_out=1B02EFFC7072 with key_round=0 and key_last=1.
- Backpressure: key_ready toggled randomly → key_out/key_round held while stalled, and exactly 16 transfers occur, matching the unstalled sequence.
- Start while busy (pulse at j=5) → ignored; the sequence completes unchanged.
- With DES_KS_PC1_EN: raw key_in=133457799BBCDFF1 → first subkey 1B02EFFC7072.
